roi_frame_packer: RTL and testbench

//  Parametrised successor to the fixed 48-row x 16-channel selector. After the row

---
 rtl/roi_frame_packer.sv | 188 ++++++++++++++++++
 tb/tb_roi_frame_packer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/roi_frame_packer.sv
// ROI frame packer: walks the active row/pair window of the row buffers and streams
// framed 32-bit words (event header, per-row header/data/trailer, event footer) to the FIFO.
module roi_frame_packer #(
    parameter int          N_CH    = 16,
    parameter int          N_ROW   = 48,
    parameter int          ROW_W   = 6,
    parameter int          COL_W   = 4,
    parameter int          RD_LAT  = 1,
    parameter logic [31:0] EVT_HDR = 32'hAAAAAAAA,
    parameter logic [31:0] EVT_FTR = 32'hF0F0F0F0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [ROW_W-1:0]     ROW_START,
    input  logic [ROW_W-1:0]     ROW_END,
    input  logic [COL_W-1:0]     COL_START,
    input  logic [COL_W-1:0]     COL_END,
    input  logic                 SET_PARAM,
    input  logic                 FRAME_START,
    output logic [ROW_W-1:0]     MEM_ADDR_OUT,
    input  logic [16*N_CH-1:0]   MEM_DATA,
    input  logic [15:0]          ROW_HDR,
    input  logic [15:0]          ROW_FTR,
    input  logic                 FIFO_FULL,
    output logic [31:0]          DATA_OUT,
    output logic                 FIFO_WR_EN,
    output logic                 FRAME_END_FLAG,
    output logic                 BUSY,
    output logic [15:0]          EVENT_NUMBER,
    output logic [15:0]          DROP_CNT
);

    localparam int               NP      = N_CH / 2;
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(N_ROW - 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(NP - 1);
    localparam logic [1:0]       LAT     = 2'(RD_LAT);

    typedef enum logic [2:0] {IDLE, EVH, RADDR, RWAIT, RHDR, DATA, RTRL, EVF} state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t               state;
    logic [ROW_W-1:0]     row;
    logic [COL_W-1:0]     col;
    logic [1:0]           wait_cnt;
    logic [ROW_W-1:0]     pend_row_sta, pend_row_end, act_row_sta, act_row_end;
    logic [COL_W-1:0]     pend_col_sta, pend_col_end, act_col_sta, act_col_end;
    logic [16*N_CH-1:0]   row_data;
    logic [15:0]          hdr_q, ftr_q;
    logic [31:0]          pair_word;
    logic                 param_ok;
    logic                 tag_ok;

    assign MEM_ADDR_OUT = row;
    assign tag_ok       = (hdr_q[11:10] == 2'b10);
    assign param_ok     = (ROW_START <= ROW_END) && (COL_START <= COL_END) &&
                          (ROW_END <= ROW_MAX) && (COL_END <= COL_MAX);

    always_comb begin
        pair_word = '0;
        for (int p = 0; p < NP; p++) begin
            if (col == COL_W'(p)) pair_word = row_data[32*p +: 32];
        end
    end

    // Row buffer capture: data, header and footer land together RD_LAT cycles after RADDR
    always_ff @(posedge CLK) begin
        if (state == RWAIT && wait_cnt == LAT) begin
            row_data <= MEM_DATA;
            hdr_q    <= ROW_HDR;
            ftr_q    <= ROW_FTR;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state          <= IDLE;
            row            <= '0;
            col            <= '0;
            wait_cnt       <= '0;
            pend_row_sta   <= '0;
            pend_row_end   <= ROW_MAX;
            pend_col_sta   <= '0;
            pend_col_end   <= COL_MAX;
            act_row_sta    <= '0;
            act_row_end    <= ROW_MAX;
            act_col_sta    <= '0;
            act_col_end    <= COL_MAX;
            DATA_OUT       <= '0;
            FIFO_WR_EN     <= 1'b0;
            FRAME_END_FLAG <= 1'b0;
            BUSY           <= 1'b0;
            EVENT_NUMBER   <= '0;
            DROP_CNT       <= '0;
        end else begin
            FIFO_WR_EN     <= 1'b0;
            FRAME_END_FLAG <= 1'b0;
            if (SET_PARAM && param_ok) begin
                pend_row_sta <= ROW_START;
                pend_row_end <= ROW_END;
                pend_col_sta <= COL_START;
                pend_col_end <= COL_END;
            end
            if (FRAME_START && BUSY) DROP_CNT <= sat_inc(DROP_CNT);

            // Word-emitting states only advance while the FIFO has room
            case (state)
                IDLE: begin
                    if (FRAME_START) begin
                        EVENT_NUMBER <= EVENT_NUMBER + 16'd1;
                        act_row_sta  <= pend_row_sta;
                        act_row_end  <= pend_row_end;
                        act_col_sta  <= pend_col_sta;
                        act_col_end  <= pend_col_end;
                        row          <= pend_row_sta;
                        BUSY         <= 1'b1;
                        state        <= EVH;
                    end
                end
                EVH: begin
                    if (!FIFO_FULL) begin
                        FIFO_WR_EN <= 1'b1;
                        DATA_OUT   <= EVT_HDR;
                        state      <= RADDR;
                    end
                end
                RADDR: begin
                    wait_cnt <= 2'd1;
                    state    <= RWAIT;
                end
                RWAIT: begin
                    if (wait_cnt == LAT) begin
                        col   <= act_col_sta;
                        state <= RHDR;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                RHDR: begin
                    if (!FIFO_FULL) begin
                        if (tag_ok) begin
                            FIFO_WR_EN <= 1'b1;
                            DATA_OUT   <= {hdr_q, {(16-ROW_W){1'b0}}, row};
                        end
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (!FIFO_FULL) begin
                        if (tag_ok) begin
                            FIFO_WR_EN <= 1'b1;
                            DATA_OUT   <= pair_word;
                        end
                        if (col == act_col_end) state <= RTRL;
                        else                    col   <= col + 1'b1;
                    end
                end
                RTRL: begin
                    if (!FIFO_FULL) begin
                        if (tag_ok) begin
                            FIFO_WR_EN <= 1'b1;
                            DATA_OUT   <= {ftr_q, EVENT_NUMBER};
                        end
                        if (row == act_row_end) begin
                            state <= EVF;
                        end else begin
                            row   <= row + 1'b1;
                            state <= RADDR;
                        end
                    end
                end
                EVF: begin
                    if (!FIFO_FULL) begin
                        FIFO_WR_EN     <= 1'b1;
                        FRAME_END_FLAG <= 1'b1;
                        DATA_OUT       <= EVT_FTR;
                        BUSY           <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_roi_frame_packer.sv
// Bench for roi_frame_packer: directed and randomized frames compared word-by-word
// against a frame model built from the ROI, row-tag and framing rules.
`timescale 1ns/1ps
module tb_roi_frame_packer;

    localparam int          N_CH    = 16;
    localparam int          N_ROW   = 48;
    localparam int          ROW_W   = 6;
    localparam int          COL_W   = 4;
    localparam int          NP      = N_CH / 2;
    localparam logic [31:0] EVT_HDR = 32'hAAAAAAAA;
    localparam logic [31:0] EVT_FTR = 32'hF0F0F0F0;

    logic                CLK = 1'b0;
    logic                RST = 1'b0;
    logic [ROW_W-1:0]    ROW_START = '0;
    logic [ROW_W-1:0]    ROW_END = '0;
    logic [COL_W-1:0]    COL_START = '0;
    logic [COL_W-1:0]    COL_END = '0;
    logic                SET_PARAM = 1'b0;
    logic                FRAME_START = 1'b0;
    logic [ROW_W-1:0]    MEM_ADDR_OUT;
    logic [16*N_CH-1:0]  MEM_DATA = '0;
    logic [15:0]         ROW_HDR = '0;
    logic [15:0]         ROW_FTR = '0;
    logic                FIFO_FULL = 1'b0;
    logic [31:0]         DATA_OUT;
    logic                FIFO_WR_EN;
    logic                FRAME_END_FLAG;
    logic                BUSY;
    logic [15:0]         EVENT_NUMBER;
    logic [15:0]         DROP_CNT;

    roi_frame_packer dut (
        .CLK(CLK), .RST(RST),
        .ROW_START(ROW_START), .ROW_END(ROW_END),
        .COL_START(COL_START), .COL_END(COL_END),
        .SET_PARAM(SET_PARAM), .FRAME_START(FRAME_START),
        .MEM_ADDR_OUT(MEM_ADDR_OUT), .MEM_DATA(MEM_DATA),
        .ROW_HDR(ROW_HDR), .ROW_FTR(ROW_FTR),
        .FIFO_FULL(FIFO_FULL), .DATA_OUT(DATA_OUT),
        .FIFO_WR_EN(FIFO_WR_EN), .FRAME_END_FLAG(FRAME_END_FLAG),
        .BUSY(BUSY), .EVENT_NUMBER(EVENT_NUMBER), .DROP_CNT(DROP_CNT)
    );

    always #5 CLK = ~CLK;

    logic [15:0] ch_mem [N_ROW][N_CH];
    logic [15:0] hdr_mem [N_ROW];
    logic [15:0] ftr_mem [N_ROW];
    logic [32:0] got[$];
    logic [32:0] exp_q[$];
    int checks = 0, failures = 0;
    int frames_done = 0, stall_viol = 0, fd0 = 0;
    bit last_full = 1'b0;
    int pend_rs, pend_re, pend_cs, pend_ce;
    logic [15:0] model_ev;

    // Row buffer with one cycle of read latency
    always @(posedge CLK) begin
        for (int c = 0; c < N_CH; c++) MEM_DATA[16*c +: 16] <= ch_mem[MEM_ADDR_OUT][c];
        ROW_HDR <= hdr_mem[MEM_ADDR_OUT];
        ROW_FTR <= ftr_mem[MEM_ADDR_OUT];
    end

    always @(negedge CLK) begin
        if (FIFO_WR_EN) begin
            got.push_back({FRAME_END_FLAG, DATA_OUT});
            if (last_full) stall_viol++;
            if (FRAME_END_FLAG) frames_done++;
        end
        last_full = FIFO_FULL;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic build_model(input int rs, input int re, input int cs, input int ce,
                               input logic [15:0] evn);
        exp_q.delete();
        exp_q.push_back({1'b0, EVT_HDR});
        for (int r = rs; r <= re; r++) begin
            if (hdr_mem[r][11:10] == 2'b10) begin
                exp_q.push_back({1'b0, hdr_mem[r], 10'd0, 6'(r)});
                for (int p = cs; p <= ce; p++)
                    exp_q.push_back({1'b0, ch_mem[r][2*p+1], ch_mem[r][2*p]});
                exp_q.push_back({1'b0, ftr_mem[r], evn});
            end
        end
        exp_q.push_back({1'b1, EVT_FTR});
    endtask

    task automatic pulse_frame();
        @(posedge CLK); #1 FRAME_START = 1'b1;
        @(posedge CLK); #1 FRAME_START = 1'b0;
    endtask

    task automatic set_param(input int rs, input int re, input int cs, input int ce);
        @(posedge CLK); #1;
        ROW_START = 6'(rs); ROW_END = 6'(re); COL_START = 4'(cs); COL_END = 4'(ce);
        SET_PARAM = 1'b1;
        @(posedge CLK); #1 SET_PARAM = 1'b0;
        if (rs <= re && re < N_ROW && cs <= ce && ce < NP) begin
            pend_rs = rs; pend_re = re; pend_cs = cs; pend_ce = ce;
        end
    endtask

    task automatic start_frame();
        model_ev = model_ev + 16'd1;
        build_model(pend_rs, pend_re, pend_cs, pend_ce, model_ev);
        got.delete();
        fd0 = frames_done;
        pulse_frame();
    endtask

    task automatic finish_frame(input string tag, input bit rand_full);
        int cyc;
        int nbad;
        int n;
        cyc = 0;
        while (frames_done == fd0 && cyc < 4000) begin
            @(posedge CLK); #1;
            if (rand_full) FIFO_FULL = ($urandom_range(0, 3) == 0);
            cyc++;
        end
        FIFO_FULL = 1'b0;
        check({tag, " done"}, 64'(frames_done - fd0), 64'd1);
        repeat (3) @(posedge CLK);
        #1;
        check({tag, " len"}, 64'(got.size()), 64'(exp_q.size()));
        nbad = 0;
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (got[i] !== exp_q[i]) nbad++;
        check({tag, " bad_words"}, 64'(nbad), 64'd0);
        check({tag, " evnum"}, 64'(EVENT_NUMBER), 64'(model_ev));
    endtask

    task automatic default_roi_model();
        pend_rs = 0; pend_re = N_ROW - 1; pend_cs = 0; pend_ce = NP - 1;
        model_ev = 16'd0;
    endtask

    initial begin
        for (int r = 0; r < N_ROW; r++) begin
            for (int c = 0; c < N_CH; c++) ch_mem[r][c] = 16'($urandom);
            hdr_mem[r] = 16'($urandom);
            hdr_mem[r][11:10] = 2'b10;
            ftr_mem[r] = 16'($urandom);
        end
        default_roi_model();

        #2 RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        check("reset data/wr/flag/busy", {DATA_OUT, FIFO_WR_EN, FRAME_END_FLAG, BUSY}, 64'd0);
        check("reset evnum/drop/addr", {EVENT_NUMBER, DROP_CNT, 10'd0, MEM_ADDR_OUT}, 64'd0);

        start_frame();
        finish_frame("default", 1'b0);
        check("default len482", 64'(got.size()), 64'd482);
        check("default last flag", 64'(got[got.size()-1][32]), 64'd1);
        check("default first word", 64'(got[0]), {31'd0, 1'b0, EVT_HDR});

        set_param(5, 3, 0, 7);
        set_param(0, 47, 0, NP);
        start_frame();
        finish_frame("invalid ignored", 1'b0);
        check("invalid len482", 64'(got.size()), 64'd482);

        set_param(2, 4, 1, 2);
        start_frame();
        finish_frame("roi 2..4 1..2", 1'b0);
        check("roi len14", 64'(got.size()), 64'd14);
        check("roi row2 pair1", 64'(got[2][31:0]), 64'({ch_mem[2][3], ch_mem[2][2]}));

        set_param(0, N_ROW - 1, 0, NP - 1);
        stall_viol = 0;
        start_frame();
        repeat (20) @(posedge CLK);
        #1 FIFO_FULL = 1'b1;
        check("stall busy", 64'(BUSY), 64'd1);
        repeat (10) @(posedge CLK);
        #1 FIFO_FULL = 1'b0;
        finish_frame("stall", 1'b0);
        check("stall no write when full", 64'(stall_viol), 64'd0);

        start_frame();
        repeat (5) @(posedge CLK);
        pulse_frame();
        finish_frame("drop", 1'b0);
        check("drop cnt", 64'(DROP_CNT), 64'd1);

        hdr_mem[7][11:10] = 2'b00;
        start_frame();
        finish_frame("row7 untagged", 1'b0);
        check("row7 len472", 64'(got.size()), 64'd472);
        hdr_mem[7][11:10] = 2'b10;

        start_frame();
        repeat (10) @(posedge CLK);
        set_param(10, 11, 0, 0);
        finish_frame("set during frame", 1'b0);
        start_frame();
        finish_frame("next frame roi", 1'b0);
        check("next frame len8", 64'(got.size()), 64'd8);

        stall_viol = 0;
        for (int k = 0; k < 4; k++) begin
            int rs, re, cs, ce;
            rs = $urandom_range(0, N_ROW - 1);
            re = $urandom_range(rs, N_ROW - 1);
            cs = $urandom_range(0, NP - 1);
            ce = $urandom_range(cs, NP - 1);
            for (int r = 0; r < N_ROW; r++) hdr_mem[r] = 16'($urandom);
            set_param(rs, re, cs, ce);
            start_frame();
            finish_frame($sformatf("random%0d", k), 1'b1);
        end
        check("random no write when full", 64'(stall_viol), 64'd0);
        for (int r = 0; r < N_ROW; r++) hdr_mem[r][11:10] = 2'b10;

        start_frame();
        repeat (20) @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        check("midrst data/wr/flag/busy", {DATA_OUT, FIFO_WR_EN, FRAME_END_FLAG, BUSY}, 64'd0);
        check("midrst evnum/drop/addr", {EVENT_NUMBER, DROP_CNT, 10'd0, MEM_ADDR_OUT}, 64'd0);
        @(posedge CLK);
        #1 RST = 1'b0;
        default_roi_model();
        start_frame();
        check("post-reset evnum1", 64'(EVENT_NUMBER), 64'd1);
        finish_frame("post-reset frame", 1'b0);
        check("post-reset len482", 64'(got.size()), 64'd482);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
